// File: rtl/axi_master_bridge.sv
// axi_master_bridge: single-outstanding AXI4 master turning core read/write burst requests
// into AR/R or AW/W/B channel traffic, streaming beats through core-side valid/ready.
module axi_master_bridge #(
   parameter int                   ID_BITS   = 4,
   parameter logic [ID_BITS-1:0]   MASTER_ID = '0,
   parameter int                   LEN_BITS  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [31:0]         req_addr,
   input  logic [LEN_BITS-1:0] req_len,
   input  logic [3:0]          req_strb,
   input  logic                wd_valid,
   output logic                wd_ready,
   input  logic [31:0]         wd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [31:0]         rd_data,
   output logic                rd_last,
   output logic                done,
   output logic                err,
   output logic [ID_BITS-1:0]  AWID,
   output logic [31:0]         AWADDR,
   output logic [LEN_BITS-1:0] AWLEN,
   output logic [2:0]          AWSIZE,
   output logic [1:0]          AWBURST,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [31:0]         WDATA,
   output logic [3:0]          WSTRB,
   output logic                WLAST,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [ID_BITS-1:0]  BID,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY,
   output logic [ID_BITS-1:0]  ARID,
   output logic [31:0]         ARADDR,
   output logic [LEN_BITS-1:0] ARLEN,
   output logic [2:0]          ARSIZE,
   output logic [1:0]          ARBURST,
   output logic                ARVALID,
   input  logic                ARREADY,
   input  logic [ID_BITS-1:0]  RID,
   input  logic [31:0]         RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RLAST,
   input  logic                RVALID,
   output logic                RREADY
);
   typedef enum logic [2:0] {IDLE, RADDR, RDATA_S, WADDR, WDATA_S, WRESP} state_t;
   state_t              r_state;
   logic [31:0]         r_addr;
   logic [LEN_BITS-1:0] r_len, r_cnt;
   logic [3:0]          r_strb;
   logic                r_err;
   logic                w_rhs, w_whs, w_bhs, w_wlast, w_rerr, w_berr, w_unused;
   assign w_rhs    = r_state == RDATA_S && RVALID && rd_ready;
   assign w_whs    = r_state == WDATA_S && wd_valid && WREADY;
   assign w_bhs    = r_state == WRESP && BVALID;
   assign w_wlast  = r_cnt == r_len;
   assign w_rerr   = w_rhs && RRESP != 2'b00;
   assign w_berr   = w_bhs && BRESP != 2'b00;
   // IDs are not checked: only one transaction is ever outstanding
   assign w_unused = ^{RID, BID};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_len   <= '0;
         r_strb  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else
         case (r_state)
            IDLE: if (req_valid) begin
               r_state <= req_write ? WADDR : RADDR;
               r_addr  <= req_addr;
               r_len   <= req_len;
               r_strb  <= req_strb;
               r_err   <= 1'b0;
            end
            RADDR: if (ARREADY) r_state <= RDATA_S;
            // the slave's RLAST ends the burst even if it overruns the requested length
            RDATA_S: if (w_rhs) begin
               r_err   <= r_err | w_rerr;
               r_cnt   <= RLAST ? '0 : r_cnt + 1'b1;
               r_state <= RLAST ? IDLE : RDATA_S;
            end
            WADDR: if (AWREADY) r_state <= WDATA_S;
            WDATA_S: if (w_whs) begin
               r_cnt   <= w_wlast ? '0 : r_cnt + 1'b1;
               r_state <= w_wlast ? WRESP : WDATA_S;
            end
            WRESP: if (BVALID) begin
               r_err   <= r_err | w_berr;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
   assign req_ready = rst && r_state == IDLE;
   assign ARVALID   = r_state == RADDR;
   assign ARID      = MASTER_ID;
   assign ARADDR    = r_addr;
   assign ARLEN     = r_len;
   assign ARSIZE    = 3'b010;
   assign ARBURST   = 2'b01;
   assign AWVALID   = r_state == WADDR;
   assign AWID      = MASTER_ID;
   assign AWADDR    = r_addr;
   assign AWLEN     = r_len;
   assign AWSIZE    = 3'b010;
   assign AWBURST   = 2'b01;
   assign RREADY    = r_state == RDATA_S && rd_ready;
   assign rd_valid  = r_state == RDATA_S && RVALID;
   assign rd_data   = RDATA;
   assign rd_last   = RLAST;
   assign WVALID    = r_state == WDATA_S && wd_valid;
   assign wd_ready  = r_state == WDATA_S && WREADY;
   assign WDATA     = wd_data;
   assign WSTRB     = r_strb;
   assign WLAST     = r_state == WDATA_S && w_wlast;
   assign BREADY    = r_state == WRESP;
   assign done      = (w_rhs && RLAST) || w_bhs;
   assign err       = r_err || w_rerr || w_berr;
endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
Single-outstanding AXI4 master that turns a simple core-side request (read or write, 1-16 beat INCR burst) into AXI AW/W/B or AR/R channel traffic. It is the initiator counterpart of the peripheral slave wrappers (sensor, DRAM, ROM) and sits between a CPU/DMA port and the AXI bridge master port. Read data and write data stream beat-by-beat through valid/ready handshakes on the core side.

Parameters:
ID_BITS, 4, width of ARID/AWID/RID/BID
MASTER_ID, 4'd0, constant ID driven on ARID/AWID
LEN_BITS, 4, width of burst length fields (beats = len+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req_valid  in  1  core request valid
req_ready  out  1  bridge accepts request (IDLE only)
req_write  in  1  1=write burst, 0=read burst
req_addr  in  32  burst start address (word aligned)
req_len  in  LEN_BITS  beats minus one
req_strb  in  4  byte strobe applied to every write beat
wd_valid  in  1  core write-beat valid
wd_ready  out  1  bridge takes write beat (= WREADY in WDATA state)
wd_data  in  32  write beat data
rd_valid  out  1  read beat valid (= RVALID in RDATA state)
rd_ready  in  1  core accepts read beat
rd_data  out  32  read beat data (= RDATA)
rd_last  out  1  final read beat (= RLAST)
done  out  1  one-cycle pulse at end of transaction
err  out  1  sticky-per-transaction: any RRESP/BRESP != OKAY; valid with done
AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID_BITS/32/LEN_BITS/3/2/1  write address channel
AWREADY  in  1
WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  write data channel
WREADY  in  1
BID/BRESP/BVALID  in  ID_BITS/2/1 ; BREADY  out  1
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID_BITS/32/LEN_BITS/3/2/1  read address channel
ARREADY  in  1
RID/RDATA/RRESP/RLAST/RVALID  in  ID_BITS/32/2/1/1 ; RREADY  out  1

Behaviour:
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP. Reset -> IDLE; all VALID/READY outputs, done, err, beat counter = 0; captured addr/len/strb = 0.
- IDLE: req_ready=1. req_valid&req_write -> WADDR; req_valid&~req_write -> RADDR. Capture req_addr, req_len, req_strb on acceptance; clear err.
- RADDR: ARVALID=1 with captured addr/len, ARID=MASTER_ID, ARSIZE=3'b010, ARBURST=INCR(2'b01). ARVALID held, fields stable, until ARREADY; then RDATA.
- RDATA: RREADY=rd_ready, rd_valid=RVALID. Each RVALID&RREADY: OR (RRESP!=OKAY) into err, counter++. Beat with RLAST -> IDLE, done=1 that cycle (combinational with last handshake), counter cleared. If counter reaches len without RLAST, keep accepting until RLAST (slave is authoritative).
- WADDR: AWVALID=1, same field rules; AWREADY -> WDATA. AW always completes before first W beat.
- WDATA: WVALID=wd_valid, WDATA=wd_data, WSTRB=captured strb, WLAST=(counter==len), wd_ready=WREADY. Each WVALID&WREADY counter++; beat with WLAST -> WRESP, counter cleared.
- WRESP: BREADY=1; BVALID -> IDLE, err|=(BRESP!=OKAY), done=1 that cycle.
- RID/BID not checked (single outstanding).
- Counter width LEN_BITS; len=15 yields 16 beats with no overflow before WLAST.
- New request accepted no earlier than the cycle after done (req_ready only in IDLE).
- Reset mid-burst: immediate return to IDLE, all VALIDs drop asynchronously; no completion of the burst.
- Core stalls (wd_valid=0 / rd_ready=0) hold state indefinitely; no timeout.

Test Plan:
- Single read: req addr 0x1000_0100, len 0; ARREADY after 2 cycles; RDATA=0xDEAD_BEEF RLAST=1 -> ARLEN=0, rd_data=0xDEAD_BEEF, done pulse, err=0.
- 4-beat write: addr 0x2000_0000, len 3, strb 4'hF, data 1..4 with WREADY toggling -> AW before W, 4 beats in order, WLAST only on beat 4, done on BVALID, err=0.
- Read backpressure: len 3, rd_ready low 3 cycles mid-burst -> RREADY low, no beat lost/duplicated, done on 4th beat.
- Error resp: write len 0, BRESP=2'b10 -> done with err=1; next read OKAY -> err=0.
- Max burst: read len 15 -> 16 beats accepted, counter no wrap, done after RLAST.
- Async reset asserted during WDATA beat 2 -> AWVALID/WVALID/BREADY=0 immediately, state IDLE, req_ready=1 after release.
